register_file_wb: RTL and testbench
===================================

Name: register_file_wb

Overview:
- Writeback-stage register file for the 16-bit core: 8 x 16-bit general registers.
- Consumes write_add / writeOrder from the write-address decoder, plus the writeback data.
- Supplies two registered read operands to the execute stage.
- Commits a write only in the writeback phase of the 5-phase instruction cycle.

Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 3, register index width; register count = 2**ADDR_W
- RD_PHASE, 1, phase value in which read operands are captured
- WB_PHASE, 4, phase value in which a write is committed

Ports:
- clock  input  1  system clock; all state updates on posedge
- reset  input  1  synchronous, active-high
- phase  input  3  current instruction phase, 0..4; values 5..7 are illegal
- rd_add_a  input  ADDR_W  read port A index (Rs)
- rd_add_b  input  ADDR_W  read port B index (Rd/Rb)
- write_add  input  ADDR_W  write index from the address decoder
- writeOrder  input  1  write request from the address decoder
- wb_data  input  DATA_W  result to be written
- rd_data_a  output  DATA_W  registered operand A
- rd_data_b  output  DATA_W  registered operand B
- wb_done  output  1  pulse: a write was committed last cycle
- dbg_sel  input  ADDR_W  debug read select
- dbg_data  output  DATA_W  combinational view of reg[dbg_sel]

Behaviour:
- Reset (reset=1 at posedge):
  - all registers, rd_data_a, rd_data_b = 0; wb_done = 0.
  - Reset dominates any same-cycle write or read capture.
  - Reset mid-instruction discards pending operands; no partial write is committed.
- Input timing: write_add and writeOrder change on negedge clock and are sampled here on the following posedge. No extra synchronisation.
- Read capture:
  - at posedge with phase==RD_PHASE: rd_data_a <= reg[rd_add_a], rd_data_b <= reg[rd_add_b].
  - Otherwise both hold.
  - Latency 1 cycle from the capture edge.
- Write commit:
  - at posedge with phase==WB_PHASE and writeOrder==1: reg[write_add] <= wb_data, and wb_done <= 1 for exactly one cycle.
  - writeOrder==1 in any other phase is ignored: no write, wb_done stays 0.
- Register 0 is a normal writable register; no hard-wired zero.
- Illegal phase (5..7): no read capture, no write; outputs hold.
- Same-cycle read and write: not possible with RD_PHASE != WB_PHASE. If parameters are set equal, behaviour is governed by the optional feature.
- dbg_data is purely combinational from register state. It has no effect on the datapath.
- Width rules: no arithmetic. Indices are used unsigned and are always in range (2**ADDR_W entries).

Optional Feature:
- Macro REGFILE_WB_BYPASS_EN.
- Defined: when a read capture and a write commit fall on the same posedge (RD_PHASE==WB_PHASE configuration, or phase-override test mode) and rd_add_x==write_add, rd_data_x captures wb_data (new value). The bypass is applied per port independently.
- Not defined: the read captures the pre-write register content (old value).
- Either way the register array updates identically.

Decomposition:
- Shared package core_pkg holds:
  - DATA_W and ADDR_W constants
  - phase constants P_FETCH=0, P_READ=1, P_EXEC=2, P_MEM=3, P_WB=4
  - op1 encoding constants shared with the write-address decoder
- One sub-module, regfile_read_port, is instantiated twice (A and B):
  - array mux, optional bypass mux, output register with hold.

Test Plan:
- Reset: write 0xBEEF to r3, assert reset for 1 cycle -> r3=0, rd_data_a=rd_data_b=0, wb_done=0.
- Basic write/read:
  - phase=4, writeOrder=1, write_add=5, wb_data=0x1234 -> wb_done=1 next cycle.
  - next phase=1, rd_add_a=5 -> rd_data_a=0x1234 one cycle later.
- Gating: writeOrder=1, write_add=2, wb_data=0xAAAA with phase=0..3 and 5..7 -> r2 unchanged (dbg_data=0), wb_done stays 0.
- Disabled write: phase=4, writeOrder=0, write_add=6, wb_data=0xFFFF -> r6 unchanged, wb_done=0.
- Dual read: r1=0x0011, r7=0x7700, phase=1, rd_add_a=1, rd_add_b=7 -> rd_data_a=0x0011, rd_data_b=0x7700. Both hold through phases 2..4 despite index changes.
- Bypass (RD_PHASE=WB_PHASE=4): r4=0x0001, write 0x0BAD to r4 with rd_add_a=4 ->
  - with REGFILE_WB_BYPASS_EN: rd_data_a=0x0BAD
  - without: rd_data_a=0x0001
  - in both cases r4=0x0BAD afterwards.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core constants: datapath widths, instruction-cycle phases and the
// op1 encodings used by the write-address decoder.
package core_pkg;

  localparam int CORE_DATA_W = 16;
  localparam int CORE_ADDR_W = 3;

  typedef enum logic [2:0] {
    P_FETCH = 3'd0,
    P_READ  = 3'd1,
    P_EXEC  = 3'd2,
    P_MEM   = 3'd3,
    P_WB    = 3'd4
  } phase_e;

  localparam logic [1:0] OP1_ALU    = 2'b00;
  localparam logic [1:0] OP1_LOAD   = 2'b01;
  localparam logic [1:0] OP1_STORE  = 2'b10;
  localparam logic [1:0] OP1_BRANCH = 2'b11;

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: array mux, optional write bypass, hold register.
// Bypass is compiled in with REGFILE_WB_BYPASS_EN.
module regfile_read_port
  import core_pkg::*;
#(
  parameter int DATA_W = CORE_DATA_W,
  parameter int ADDR_W = CORE_ADDR_W
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                cap_en,
  input  logic [ADDR_W-1:0]                   rd_add,
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]  regs,
  input  logic                                wr_en,
  input  logic [ADDR_W-1:0]                   wr_add,
  input  logic [DATA_W-1:0]                   wb_data,
  output logic [DATA_W-1:0]                   rd_data
);

`ifdef REGFILE_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [DATA_W-1:0] sel;

  // Only a same-edge commit can hit here; otherwise the array is already current.
  always_comb begin
    sel = regs[rd_add];
    if (BYPASS && wr_en && (wr_add == rd_add)) sel = wb_data;
  end

  always_ff @(posedge clock) begin
    if (reset)       rd_data <= '0;
    else if (cap_en) rd_data <= sel;
  end

endmodule

// File: rtl/register_file_wb.sv
// Writeback-stage register file: 2**ADDR_W x DATA_W, two registered read ports,
// phase-gated write commit. Optional same-edge bypass: REGFILE_WB_BYPASS_EN.
module register_file_wb
  import core_pkg::*;
#(
  parameter int DATA_W   = CORE_DATA_W,
  parameter int ADDR_W   = CORE_ADDR_W,
  parameter int RD_PHASE = P_READ,
  parameter int WB_PHASE = P_WB
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [2:0]        phase,
  input  logic [ADDR_W-1:0] rd_add_a,
  input  logic [ADDR_W-1:0] rd_add_b,
  input  logic [ADDR_W-1:0] write_add,
  input  logic              writeOrder,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              wb_done,
  input  logic [ADDR_W-1:0] dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int         NREG      = 2**ADDR_W;
  localparam int         NUM_PORTS = 2;
  localparam logic [2:0] RD_P      = 3'(RD_PHASE);
  localparam logic [2:0] WB_P      = 3'(WB_PHASE);

  logic [NREG-1:0][DATA_W-1:0]      regs;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] rd_add;
  logic [NUM_PORTS-1:0][DATA_W-1:0] rd_q;
  logic                             rd_en, wr_en;

  // Illegal phases 5..7 never match either constant, so they fall out as no-ops.
  assign rd_en = (phase == RD_P);
  assign wr_en = (phase == WB_P) && writeOrder;

  always_ff @(posedge clock) begin
    if (reset) begin
      regs    <= '0;
      wb_done <= 1'b0;
    end else begin
      wb_done <= wr_en;
      if (wr_en) regs[write_add] <= wb_data;
    end
  end

  assign rd_add = {rd_add_b, rd_add_a};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    regfile_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_port (
      .clock   (clock),
      .reset   (reset),
      .cap_en  (rd_en),
      .rd_add  (rd_add[p]),
      .regs    (regs),
      .wr_en   (wr_en),
      .wr_add  (write_add),
      .wb_data (wb_data),
      .rd_data (rd_q[p])
    );
  end

  assign rd_data_a = rd_q[0];
  assign rd_data_b = rd_q[1];
  assign dbg_data  = regs[dbg_sel];

endmodule

// File: tb/tb_register_file_wb.sv
// Self-checking bench for register_file_wb: directed scenarios plus random
// traffic against an array-based model; a second instance covers RD==WB phase.
module tb_register_file_wb;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  phase;
  logic [2:0]  rd_add_a, rd_add_b, write_add, dbg_sel;
  logic        writeOrder;
  logic [15:0] wb_data;
  logic [15:0] rd_data_a, rd_data_b, dbg_data;
  logic        wb_done;
  logic [15:0] rd2_a, rd2_b, dbg2;
  logic        done2;

  int errors = 0;
  int checks = 0;

  logic [15:0] m_regs [8];
  logic [15:0] m_a, m_b;
  logic        m_done;

  always #5 clk = ~clk;

  register_file_wb dut (
    .clock(clk), .reset(reset), .phase(phase),
    .rd_add_a(rd_add_a), .rd_add_b(rd_add_b),
    .write_add(write_add), .writeOrder(writeOrder), .wb_data(wb_data),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .wb_done(wb_done),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  register_file_wb #(.RD_PHASE(4), .WB_PHASE(4)) dut_same (
    .clock(clk), .reset(reset), .phase(phase),
    .rd_add_a(rd_add_a), .rd_add_b(rd_add_b),
    .write_add(write_add), .writeOrder(writeOrder), .wb_data(wb_data),
    .rd_data_a(rd2_a), .rd_data_b(rd2_b), .wb_done(done2),
    .dbg_sel(dbg_sel), .dbg_data(dbg2)
  );

  // Drive one cycle from a negedge, advance the model at the posedge, return at the next negedge.
  task automatic cyc(input logic [2:0] ph, input logic [2:0] ra, input logic [2:0] rb,
                     input logic [2:0] wa, input logic wo, input logic [15:0] wd,
                     input logic rst);
    phase = ph; rd_add_a = ra; rd_add_b = rb; write_add = wa;
    writeOrder = wo; wb_data = wd; reset = rst;
    @(posedge clk);
    if (rst) begin
      foreach (m_regs[i]) m_regs[i] = '0;
      m_a = '0; m_b = '0; m_done = 1'b0;
    end else begin
      if (ph == 3'd1) begin m_a = m_regs[ra]; m_b = m_regs[rb]; end
      m_done = (ph == 3'd4) && wo;
      if (m_done) m_regs[wa] = wd;
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    cyc(3'd4, 3'd0, 3'd0, 3'd3, 1'b1, 16'hBEEF, 1'b0);
    cyc(3'd1, 3'd3, 3'd3, 3'd0, 1'b0, 16'h0000, 1'b0);
    dbg_sel = 3'd3; #1;
    checks++;
    if (dbg_data !== 16'hBEEF) begin errors++; $display("FAIL reset_pre_r3 got=%h exp=%h", dbg_data, 16'hBEEF); end
    // Reset dominates a same-edge write and read capture.
    cyc(3'd4, 3'd3, 3'd3, 3'd3, 1'b1, 16'h5555, 1'b1);
    dbg_sel = 3'd3; #1;
    checks++;
    if (dbg_data !== 16'h0000) begin errors++; $display("FAIL reset_r3 got=%h exp=0000", dbg_data); end
    checks++;
    if (rd_data_a !== 16'h0 || rd_data_b !== 16'h0) begin errors++; $display("FAIL reset_rd got=%h/%h exp=0000/0000", rd_data_a, rd_data_b); end
    checks++;
    if (wb_done !== 1'b0) begin errors++; $display("FAIL reset_wb_done got=%b exp=0", wb_done); end
  endtask

  task automatic test_basic();
    cyc(3'd4, 3'd0, 3'd0, 3'd5, 1'b1, 16'h1234, 1'b0);
    checks++;
    if (wb_done !== 1'b1) begin errors++; $display("FAIL basic_wb_done got=%b exp=1", wb_done); end
    cyc(3'd1, 3'd5, 3'd0, 3'd0, 1'b0, 16'h0, 1'b0);
    checks++;
    if (wb_done !== 1'b0) begin errors++; $display("FAIL basic_wb_done_pulse got=%b exp=0", wb_done); end
    checks++;
    if (rd_data_a !== 16'h1234) begin errors++; $display("FAIL basic_rd_a got=%h exp=1234", rd_data_a); end
  endtask

  task automatic test_gating();
    logic [2:0] phs [7];
    phs = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
    cyc(3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0, 1'b1);
    foreach (phs[i]) begin
      cyc(phs[i], 3'd2, 3'd2, 3'd2, 1'b1, 16'hAAAA, 1'b0);
      dbg_sel = 3'd2; #1;
      checks++;
      if (dbg_data !== 16'h0000 || wb_done !== 1'b0)
        begin errors++; $display("FAIL gating_ph%0d got r2=%h done=%b exp r2=0000 done=0", phs[i], dbg_data, wb_done); end
    end
  endtask

  task automatic test_disabled();
    cyc(3'd4, 3'd0, 3'd0, 3'd6, 1'b0, 16'hFFFF, 1'b0);
    dbg_sel = 3'd6; #1;
    checks++;
    if (dbg_data !== m_regs[6] || wb_done !== 1'b0)
      begin errors++; $display("FAIL disabled got r6=%h done=%b exp r6=%h done=0", dbg_data, wb_done, m_regs[6]); end
  endtask

  task automatic test_dual_read();
    cyc(3'd4, 3'd0, 3'd0, 3'd1, 1'b1, 16'h0011, 1'b0);
    cyc(3'd4, 3'd0, 3'd0, 3'd7, 1'b1, 16'h7700, 1'b0);
    cyc(3'd1, 3'd1, 3'd7, 3'd0, 1'b0, 16'h0, 1'b0);
    checks++;
    if (rd_data_a !== 16'h0011 || rd_data_b !== 16'h7700)
      begin errors++; $display("FAIL dual_read got=%h/%h exp=0011/7700", rd_data_a, rd_data_b); end
    for (int p = 2; p <= 4; p++) begin
      cyc(3'(p), 3'(p), 3'(p + 1), 3'd0, 1'b0, 16'h0, 1'b0);
      checks++;
      if (rd_data_a !== 16'h0011 || rd_data_b !== 16'h7700)
        begin errors++; $display("FAIL dual_hold_ph%0d got=%h/%h exp=0011/7700", p, rd_data_a, rd_data_b); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      cyc(3'($urandom_range(0, 7)), 3'($urandom), 3'($urandom), 3'($urandom),
          1'($urandom), 16'($urandom), ($urandom_range(0, 59) == 0));
      dbg_sel = 3'($urandom); #1;
      checks++;
      if (rd_data_a !== m_a || rd_data_b !== m_b || wb_done !== m_done || dbg_data !== m_regs[dbg_sel])
        begin
          errors++;
          $display("FAIL random_%0d got a=%h b=%h done=%b dbg=%h exp a=%h b=%h done=%b dbg=%h",
                   n, rd_data_a, rd_data_b, wb_done, dbg_data, m_a, m_b, m_done, m_regs[dbg_sel]);
        end
    end
  endtask

  task automatic test_bypass();
    logic [15:0] exp_a;
`ifdef REGFILE_WB_BYPASS_EN
    exp_a = 16'h0BAD;
`else
    exp_a = 16'h0001;
`endif
    cyc(3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0, 1'b1);
    cyc(3'd4, 3'd4, 3'd4, 3'd4, 1'b1, 16'h0001, 1'b0);
    cyc(3'd4, 3'd4, 3'd0, 3'd4, 1'b1, 16'h0BAD, 1'b0);
    checks++;
    if (rd2_a !== exp_a) begin errors++; $display("FAIL bypass_rd_a got=%h exp=%h", rd2_a, exp_a); end
    checks++;
    if (rd2_b !== 16'h0000) begin errors++; $display("FAIL bypass_rd_b_other got=%h exp=0000", rd2_b); end
    dbg_sel = 3'd4; #1;
    checks++;
    if (dbg2 !== 16'h0BAD || done2 !== 1'b1)
      begin errors++; $display("FAIL bypass_r4 got r4=%h done=%b exp r4=0bad done=1", dbg2, done2); end
  endtask

  initial begin
    reset = 1'b1; phase = '0; rd_add_a = '0; rd_add_b = '0; write_add = '0;
    writeOrder = 1'b0; wb_data = '0; dbg_sel = '0;
    @(negedge clk);
    cyc(3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0, 1'b1);
    test_reset();
    test_basic();
    test_gating();
    test_disabled();
    test_dual_read();
    test_random();
    test_bypass();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
